// File: rtl/ex_muldiv_sequencer.sv
// Iterative EX-stage multiply/divide/modulus sequencer: one bit per cycle, stalls the pipeline until MD_Result is ready.
// Optional feature macro: MD_SIGNED_EN (two's-complement Div/Mod; Mul is sign-agnostic in its low half).
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EX_valid,
    input  logic            EX_flush,
    input  logic [21:9]     ALU_Signals,
    input  logic [XLEN-1:0] Operand_EX_A,
    input  logic [XLEN-1:0] Operand_EX_B,
    output logic            EX_stall,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [XLEN-1:0] MD_Result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_DIV,
        OP_MOD
    } op_t;

    state_t          state_reg, state_next;
    op_t             op_reg, op_next;
    logic [CW-1:0]   count_reg, count_next;
    // acc: product accumulator (Mul) or partial remainder (Div/Mod)
    logic [XLEN-1:0] acc_reg, acc_next;
    // a: multiplicand (Mul) or dividend shifting into quotient (Div/Mod)
    logic [XLEN-1:0] a_reg, a_next;
    // b: multiplier (Mul) or divisor (Div/Mod)
    logic [XLEN-1:0] b_reg, b_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            busy_reg;

    logic            alu_basic;
    logic            md_req;
    logic            start;
    op_t             start_op;
    logic            div_by_zero;
    logic [XLEN-1:0] a_load;
    logic [XLEN-1:0] b_load;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic            rem_ge;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_value;
    logic            unused_alu_bits;

    assign unused_alu_bits = ^ALU_Signals[21:15];

    // Add/Sub/Cmp win over the multi-cycle ops
    assign alu_basic = |ALU_Signals[11:9];
    assign md_req    = |ALU_Signals[14:12];
    assign start     = EX_valid && !alu_basic && md_req;

    always_comb begin
        start_op = OP_MOD;
        if (ALU_Signals[12]) begin
            start_op = OP_MUL;
        end else if (ALU_Signals[13]) begin
            start_op = OP_DIV;
        end
    end

    assign div_by_zero = (start_op != OP_MUL) && (Operand_EX_B == '0);

`ifdef MD_SIGNED_EN
    logic sign_a_reg, sign_a_next;
    logic sign_b_reg, sign_b_next;
    logic in_sign_a;
    logic in_sign_b;

    assign in_sign_a = (start_op != OP_MUL) && Operand_EX_A[XLEN-1];
    assign in_sign_b = (start_op != OP_MUL) && Operand_EX_B[XLEN-1];
    assign a_load    = in_sign_a ? -Operand_EX_A : Operand_EX_A;
    assign b_load    = in_sign_b ? -Operand_EX_B : Operand_EX_B;
    // Truncation toward zero: quotient sign is the XOR, remainder follows the dividend
    assign quot_fix  = (sign_a_reg ^ sign_b_reg) ? -a_reg : a_reg;
    assign rem_fix   = sign_a_reg ? -acc_reg : acc_reg;
`else
    assign a_load    = Operand_EX_A;
    assign b_load    = Operand_EX_B;
    assign quot_fix  = a_reg;
    assign rem_fix   = acc_reg;
`endif

    // Restoring-division step: bring in the next dividend bit, trial-subtract the divisor
    assign rem_shift = {acc_reg, a_reg[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, b_reg};
    assign rem_ge    = (rem_shift >= {1'b0, b_reg});

    always_comb begin
        fix_value = acc_reg;
        case (op_reg)
            OP_DIV:  fix_value = quot_fix;
            OP_MOD:  fix_value = rem_fix;
            default: fix_value = acc_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
`ifdef MD_SIGNED_EN
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start && !EX_flush) begin
                    op_next = start_op;
`ifdef MD_SIGNED_EN
                    sign_a_next = in_sign_a;
                    sign_b_next = in_sign_b;
`endif
                    if (div_by_zero) begin
                        result_next = (start_op == OP_DIV) ? '1 : Operand_EX_A;
                        state_next  = S_DONE;
                    end else begin
                        count_next = CW'(XLEN);
                        acc_next   = '0;
                        a_next     = a_load;
                        b_next     = b_load;
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (EX_flush) begin
                    state_next = S_IDLE;
                end else begin
                    if (op_reg == OP_MUL) begin
                        if (b_reg[0]) begin
                            acc_next = acc_reg + a_reg;
                        end
                        a_next = a_reg << 1;
                        b_next = b_reg >> 1;
                    end else if (rem_ge) begin
                        acc_next = rem_diff[XLEN-1:0];
                        a_next   = {a_reg[XLEN-2:0], 1'b1};
                    end else begin
                        acc_next = rem_shift[XLEN-1:0];
                        a_next   = {a_reg[XLEN-2:0], 1'b0};
                    end
                    count_next = count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_next = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (EX_flush) begin
                    state_next = S_IDLE;
                end else begin
                    result_next = fix_value;
                    state_next  = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= OP_MUL;
            count_reg  <= '0;
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            busy_reg   <= (state_next != S_IDLE);
        end
    end

`ifdef MD_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
        end else begin
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
        end
    end
`endif

    // Reset gates the start term so the stall drops the moment rst_n falls
    assign EX_stall  = rst_n && !EX_flush &&
                       (((state_reg == S_IDLE) && start) ||
                        (state_reg == S_CALC) || (state_reg == S_FIX));
    assign MD_done   = (state_reg == S_DONE) && !EX_flush;
    assign MD_busy   = busy_reg;
    assign MD_Result = result_reg;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Randomized + directed bench for ex_muldiv_sequencer against an arithmetic reference model.
// Honours MD_SIGNED_EN so the model matches the build under test.
module tb_ex_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam logic [21:9] ALU_ADD = 13'h0001;
    localparam logic [21:9] ALU_MUL = 13'h0008;
    localparam logic [21:9] ALU_DIV = 13'h0010;
    localparam logic [21:9] ALU_MOD = 13'h0020;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            EX_valid = 1'b0;
    logic            EX_flush = 1'b0;
    logic [21:9]     ALU_Signals = '0;
    logic [XLEN-1:0] Operand_EX_A = '0;
    logic [XLEN-1:0] Operand_EX_B = '0;
    logic            EX_stall;
    logic            MD_busy;
    logic            MD_done;
    logic [XLEN-1:0] MD_Result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EX_valid     (EX_valid),
        .EX_flush     (EX_flush),
        .ALU_Signals  (ALU_Signals),
        .Operand_EX_A (Operand_EX_A),
        .Operand_EX_B (Operand_EX_B),
        .EX_stall     (EX_stall),
        .MD_busy      (MD_busy),
        .MD_done      (MD_done),
        .MD_Result    (MD_Result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 = Mul, 1 = Div, 2 = Mod, -1 = not a multi-cycle op
    function automatic int decode_op(input logic [21:9] alu);
        if (alu[9] || alu[10] || alu[11]) return -1;
        if (alu[12]) return 0;
        if (alu[13]) return 1;
        if (alu[14]) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (op == 0) begin
            p = {32'b0, a} * {32'b0, b};
            return p[31:0];
        end
        if (b == 0) return (op == 1) ? 32'hFFFF_FFFF : a;
`ifdef MD_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
`endif
        q = sa / sb;
        r = sa % sb;
        return (op == 1) ? q[31:0] : r[31:0];
    endfunction

    // Called at a falling edge; issues one op in cycle T and follows it to completion.
    task automatic run_op(input logic [21:9] alu, input logic [31:0] a, input logic [31:0] b);
        int op;
        int exp_lat;
        int cycles;
        int stall_cycles;
        logic [31:0] exp;
        logic seen;
        op = decode_op(alu);
        exp = ref_result(op, a, b);
        exp_lat = (op != 0 && b == 0) ? 1 : XLEN + 2;
        EX_valid = 1'b1;
        ALU_Signals = alu;
        Operand_EX_A = a;
        Operand_EX_B = b;
        #1;
        check_eq("stall_T", {31'b0, EX_stall}, 32'd1);
        stall_cycles = EX_stall ? 1 : 0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) check_eq("busy_T1", {31'b0, MD_busy}, 32'd1);
            if (MD_done) begin
                seen = 1'b1;
                check_eq("latency", cycles, exp_lat);
                check_eq("stall_cnt", stall_cycles, exp_lat);
                check_eq("stall_done", {31'b0, EX_stall}, 32'd0);
                check_eq("result", MD_Result, exp);
                EX_valid = 1'b0;
                ALU_Signals = '0;
            end else begin
                if (EX_stall) stall_cycles++;
                // operands may change once the op has been latched
                Operand_EX_A = $urandom;
                Operand_EX_B = $urandom;
            end
        end
        if (!seen) begin
            check_eq("timeout", 32'd0, 32'd1);
            EX_valid = 1'b0;
            ALU_Signals = '0;
        end
        $display("op=%0d a=%h b=%h result=%h exp=%h lat=%0d", op, a, b, MD_Result, exp, cycles);
        @(negedge clk);
        check_eq("done_pulse", {31'b0, MD_done}, 32'd0);
        check_eq("busy_idle", {31'b0, MD_busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        logic [21:9] alu;
        logic [31:0] ra, rb;
        logic seen_done;

        #1;
        check_eq("rst_stall", {31'b0, EX_stall}, 32'd0);
        check_eq("rst_busy", {31'b0, MD_busy}, 32'd0);
        check_eq("rst_done", {31'b0, MD_done}, 32'd0);
        check_eq("rst_result", MD_Result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(ALU_MUL, 32'd7, 32'd6);
        run_op(ALU_DIV, 32'd100, 32'd7);
        run_op(ALU_MOD, 32'd100, 32'd7);
        run_op(ALU_DIV, 32'd5, 32'd0);
        run_op(ALU_MOD, 32'd5, 32'd0);
        run_op(ALU_MUL | ALU_DIV, 32'd9, 32'd3);
`ifdef MD_SIGNED_EN
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(ALU_MOD, 32'hFFFF_FFF9, 32'd2);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 2))
                0: alu = ALU_MUL;
                1: alu = ALU_DIV;
                default: alu = ALU_MOD;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1, 2: rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            run_op(alu, ra, rb);
        end

        // Flush a Div during CALC, then issue a Mul two cycles later
        saved = MD_Result;
        EX_valid = 1'b1;
        ALU_Signals = ALU_DIV;
        Operand_EX_A = 32'd1000;
        Operand_EX_B = 32'd3;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (MD_done) seen_done = 1'b1;
        end
        EX_flush = 1'b1;
        EX_valid = 1'b0;
        ALU_Signals = '0;
        @(negedge clk);
        EX_flush = 1'b0;
        check_eq("flush_busy", {31'b0, MD_busy}, 32'd0);
        check_eq("flush_done", {31'b0, MD_done | seen_done}, 32'd0);
        check_eq("flush_result", MD_Result, saved);
        $display("flush at T+10: busy=%0d done=%0d result=%h", MD_busy, MD_done, MD_Result);
        @(negedge clk);
        run_op(ALU_MUL, 32'd123, 32'd45);

        // Reset in the middle of a Mul
        EX_valid = 1'b1;
        ALU_Signals = ALU_MUL;
        Operand_EX_A = 32'd11;
        Operand_EX_B = 32'd13;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_stall", {31'b0, EX_stall}, 32'd0);
        check_eq("arst_busy", {31'b0, MD_busy}, 32'd0);
        check_eq("arst_done", {31'b0, MD_done}, 32'd0);
        check_eq("arst_result", MD_Result, 32'd0);
        $display("reset at T+5: stall=%0d busy=%0d result=%h", EX_stall, MD_busy, MD_Result);
        @(negedge clk);
        rst_n = 1'b1;
        ALU_Signals = ALU_ADD;
        #1;
        check_eq("add_stall", {31'b0, EX_stall}, 32'd0);
        @(negedge clk);
        check_eq("add_busy", {31'b0, MD_busy}, 32'd0);
        check_eq("add_done", {31'b0, MD_done}, 32'd0);
        $display("add after reset: stall=%0d busy=%0d", EX_stall, MD_busy);

        // Add together with Mul: Add wins, nothing starts
        ALU_Signals = ALU_ADD | ALU_MUL;
        #1;
        check_eq("addmul_stall", {31'b0, EX_stall}, 32'd0);
        @(negedge clk);
        check_eq("addmul_busy", {31'b0, MD_busy}, 32'd0);
        $display("add+mul: stall=%0d busy=%0d", EX_stall, MD_busy);
        EX_valid = 1'b0;
        ALU_Signals = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
# ex_muldiv_sequencer

Multi-cycle sequencer for the EX-stage multiply, divide and modulus operations. It takes these operations off the single-cycle ALU path and runs them iteratively, one bit per cycle. It holds the pipeline through `EX_stall` until the result is ready, then presents `MD_Result` with a one-cycle `MD_done` strobe. The EX-stage result mux uses `MD_Result` in place of `EX_ALU_Result` when `MD_done` is high.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `EX_valid`, input, 1: EX stage holds a valid instruction.
- `EX_flush`, input, 1: synchronous kill of the in-flight operation.
- `ALU_Signals`, input, [21:9]: one-hot op decode; bit 12 Mul, bit 13 Div, bit 14 Mod; bits 9–11 (Add/Sub/Cmp) take priority.
- `Operand_EX_A`, input, XLEN: dividend or multiplicand.
- `Operand_EX_B`, input, XLEN: divisor or multiplier.
- `EX_stall`, output, 1: freeze IF/ID/EX registers.
- `MD_busy`, output, 1: the FSM is not in IDLE.
- `MD_done`, output, 1: one-cycle strobe; `MD_Result` is valid.
- `MD_Result`, output, XLEN: product (low XLEN bits), quotient or remainder.

## Operation
- Start condition: `EX_valid` is high, no bit 9–11 is set, and any of bits 12–14 is set.
  - Priority among the three: Mul > Div > Mod.
  - On the start edge the sequencer latches the operands, the op and the operand signs.
- FSM states are IDLE, CALC, FIX and DONE.
- IDLE:
  - On start with Div/Mod and B == 0, go to DONE.
  - On any other start, go to CALC and load count = XLEN.
- CALC:
  - Mul: shift-add; if multiplier bit 0 is set, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1.
  - Div/Mod: restoring division; remainder = {remainder, dividend MSB}; if remainder ≥ divisor, subtract and shift in 1, else shift in 0.
  - count decrements each cycle; when count == 1, go to FIX.
- FIX:
  - Apply sign correction (see Configuration).
  - Select the quotient, the remainder or the product low half.
  - Register the value into `MD_Result`; go to DONE.
- DONE: assert `MD_done`; go to IDLE unconditionally. The same instruction is never restarted.
- Divide by zero:
  - Div returns all ones (0xFFFFFFFF).
  - Mod returns A.
- Signed overflow: 0x80000000 / −1 gives quotient 0x80000000 and remainder 0.
- `EX_flush` while busy:
  - Next state is IDLE.
  - `MD_done` is not asserted.
  - `MD_Result` keeps its last value.
- `EX_flush` in IDLE with a start present suppresses the start.
- Non-Mul/Div/Mod instructions pass through with no stall.

## Timing
- Reset values:
  - State is IDLE.
  - `EX_stall`, `MD_busy` and `MD_done` are 0.
  - `MD_Result` is 0.
  - Internal accumulators and counter are 0.
- Cycle T is the start cycle (IDLE with the start condition true).
  - `EX_stall` is combinational and high in cycle T.
  - It stays high through CALC and FIX and is low in DONE, so the pipeline advances at the end of the DONE cycle.
- Normal op timeline:
  - CALC: T+1 … T+XLEN.
  - FIX: T+XLEN+1.
  - DONE: T+XLEN+2, with `MD_done` high.
  - Total latency is XLEN+2 cycles after T, i.e. 34 for XLEN=32.
  - `EX_stall` is high for XLEN+2 cycles (T through FIX).
- Divide-by-zero timeline: stall in T only; DONE at T+1.
- `MD_busy` is registered; it is high from T+1 until the cycle after DONE, when the FSM is back in IDLE.
- Operands and `ALU_Signals` may change after T without effect.
- `rst_n` asserted mid-operation:
  - All state clears immediately.
  - No `MD_done` is produced.
  - `EX_stall` drops asynchronously.

## Configuration
- `MD_SIGNED_EN` defined:
  - Div and Mod are two's-complement.
  - Operands are converted to magnitudes at start.
  - In FIX, the quotient is negated if signA ≠ signB, and the remainder takes the sign of A (truncation toward zero).
  - Mul is unaffected, since the low XLEN bits are sign-agnostic.
- `MD_SIGNED_EN` undefined:
  - All ops are unsigned.
  - FIX only selects the result.
  - No sign logic is instantiated.

## Test plan
- Mul, A=7, B=6 → `EX_stall` high for 34 cycles starting at T; at T+34 `MD_done`=1 and `MD_Result`=42.
- Div, A=100, B=7 → 14; Mod, same operands → 2; signed build with Div A=−7, B=2 → 0xFFFFFFFD (−3), and Mod → 0xFFFFFFFF (−1).
- Div, A=5, B=0 → `MD_done` at T+1, `MD_Result`=0xFFFFFFFF; Mod, A=5, B=0 → 5; stall lasts 1 cycle.
- Flush at T+10 of a Div → IDLE at T+11, no `MD_done`, `MD_Result` unchanged; a new Mul issued at T+12 completes normally.
- `rst_n` low at T+5 of a Mul → outputs are 0 immediately; after release, an Add instruction passes with no stall.
- `ALU_Signals` with Add and Mul both set → no start, no stall; Mul and Div both set → Mul is executed.
